// File: rtl/lc3_reg_file_cc_if.sv
// Datapath-side bundle between the LC-3 control/datapath and the register file.
// Signal names follow the LC-3 datapath figures (BUS, IR, DRMUX, ...).
interface lc3_reg_file_cc_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] BUS;
  logic [15:0]       IR;
  logic              DRMUX;
  logic              SR1MUX;
  logic              LD_REG;
  logic              LD_CC;
  logic              LD_BEN;
  logic [DATA_W-1:0] SR1_OUT;
  logic [DATA_W-1:0] SR2_OUT;
  logic [2:0]        NZP;
  logic              BEN;

  modport master (
    output BUS, IR, DRMUX, SR1MUX, LD_REG, LD_CC, LD_BEN,
    input  SR1_OUT, SR2_OUT, NZP, BEN
  );

  modport slave (
    input  BUS, IR, DRMUX, SR1MUX, LD_REG, LD_CC, LD_BEN,
    output SR1_OUT, SR2_OUT, NZP, BEN
  );
endinterface

// File: rtl/lc3_reg_file_cc.sv
// LC-3 register file R0..R7 with NZP condition codes and branch-enable flag.
// Two combinational read ports, one write port from BUS, synchronous active-low reset.
module lc3_reg_file_cc #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  lc3_reg_file_cc_if.slave      rf
);

  localparam int unsigned ADDR_W = 3;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [2:0]        r_nzp;
  logic              r_ben;

  logic [ADDR_W-1:0] w_dr;
  logic [ADDR_W-1:0] w_sr1;
  logic [ADDR_W-1:0] w_sr2;
  logic [DATA_W-1:0] w_sr1_q;
  logic [DATA_W-1:0] w_sr2_q;
  logic              w_byp_sr1;
  logic              w_byp_sr2;
  logic              w_neg;
  logic              w_zero;
  logic [2:0]        w_nzp_next;
  logic              w_ben_next;
  logic              w_unused_ir;

  // Address decode; DRMUX forces the JSR/TRAP link register R7.
  assign w_dr  = rf.DRMUX  ? ADDR_W'(7)  : rf.IR[11:9];
  assign w_sr1 = rf.SR1MUX ? rf.IR[8:6]  : rf.IR[11:9];
  assign w_sr2 = rf.IR[2:0];

  // Opcode and immediate bits are decoded elsewhere.
  assign w_unused_ir = ^{rf.IR[15:12], rf.IR[5:3]};

  // Condition codes come straight from BUS so LD_CC works without LD_REG.
  assign w_neg      = rf.BUS[DATA_W-1];
  assign w_zero     = (rf.BUS == '0);
  assign w_nzp_next = {w_neg, w_zero, ~w_neg & ~w_zero};

  // BEN samples the NZP held before this edge, even when LD_CC fires too.
  assign w_ben_next = |(rf.IR[11:9] & r_nzp);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
      r_nzp <= 3'b000;
      r_ben <= 1'b0;
    end else begin
      if (rf.LD_REG) begin
        r_regs[w_dr] <= rf.BUS;
      end
      if (rf.LD_CC) begin
        r_nzp <= w_nzp_next;
      end
      if (rf.LD_BEN) begin
        r_ben <= w_ben_next;
      end
    end
  end

  assign w_sr1_q = r_regs[w_sr1];
  assign w_sr2_q = r_regs[w_sr2];

  // Optional same-cycle forwarding of the pending write.
  assign w_byp_sr1 = BYPASS && rf.LD_REG && (w_dr == w_sr1);
  assign w_byp_sr2 = BYPASS && rf.LD_REG && (w_dr == w_sr2);

  assign rf.SR1_OUT = w_byp_sr1 ? rf.BUS : w_sr1_q;
  assign rf.SR2_OUT = w_byp_sr2 ? rf.BUS : w_sr2_q;
  assign rf.NZP     = r_nzp;
  assign rf.BEN     = r_ben;

  // Any condition-code load leaves exactly one of N/Z/P set.
  a_nzp_onehot : assert property (
    @(posedge Clk) disable iff (!Reset) rf.LD_CC |=> $onehot(r_nzp)
  );

endmodule

// File: tb/tb_lc3_reg_file_cc.sv
// Bench for lc3_reg_file_cc: BYPASS=0 and BYPASS=1 instances driven in lockstep,
// directed vector table, reset sequences and randomized traffic against a reference model.
module tb_lc3_reg_file_cc;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NVEC   = 17;

  typedef struct {
    logic        rst;
    logic [15:0] bus;
    logic [15:0] ir;
    logic        drmux;
    logic        sr1mux;
    logic        ldr;
    logic        ldc;
    logic        ldb;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [15:0] e_sr1_b0;
    logic [15:0] e_sr1_b1;
    logic [15:0] e_sr2_b0;
    logic [15:0] e_sr2_b1;
    logic [2:0]  e_nzp;
    logic        e_ben;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus;
  logic [15:0] ir;
  logic        drmux;
  logic        sr1mux;
  logic        ldr;
  logic        ldc;
  logic        ldb;

  int checks;
  int errors;

  stim_t       cur;
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic        m_ben;
  vec_t        vecs [NVEC];

  lc3_reg_file_cc_if #(.DATA_W(DATA_W)) if0 ();
  lc3_reg_file_cc_if #(.DATA_W(DATA_W)) if1 ();

  assign if0.BUS = bus;    assign if1.BUS = bus;
  assign if0.IR = ir;      assign if1.IR = ir;
  assign if0.DRMUX = drmux;   assign if1.DRMUX = drmux;
  assign if0.SR1MUX = sr1mux; assign if1.SR1MUX = sr1mux;
  assign if0.LD_REG = ldr; assign if1.LD_REG = ldr;
  assign if0.LD_CC = ldc;  assign if1.LD_CC = ldc;
  assign if0.LD_BEN = ldb; assign if1.LD_BEN = ldb;

  lc3_reg_file_cc #(.DATA_W(DATA_W), .NUM_REGS(8), .BYPASS(1'b0)) u_dut_b0 (
    .Clk(clk), .Reset(rst_n), .rf(if0)
  );
  lc3_reg_file_cc #(.DATA_W(DATA_W), .NUM_REGS(8), .BYPASS(1'b1)) u_dut_b1 (
    .Clk(clk), .Reset(rst_n), .rf(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] mk_ir(input int dr, input int s1, input int s2);
    logic [2:0] a, b, c;
    a = 3'(dr);
    b = 3'(s1);
    c = 3'(s2);
    return {4'h0, a, b, 3'b000, c};
  endfunction

  function automatic stim_t mk_s(input int rst, input int bv, input int dr, input int s1, input int s2,
                                 input int dm, input int sm, input int lr, input int lc, input int lb);
    stim_t s;
    s.rst    = 1'(rst);
    s.bus    = 16'(bv);
    s.ir     = mk_ir(dr, s1, s2);
    s.drmux  = 1'(dm);
    s.sr1mux = 1'(sm);
    s.ldr    = 1'(lr);
    s.ldc    = 1'(lc);
    s.ldb    = 1'(lb);
    return s;
  endfunction

  function automatic vec_t mk_v(input stim_t s, input int a0, input int a1, input int b0, input int b1,
                                input int nzp, input int ben);
    vec_t v;
    v.s        = s;
    v.e_sr1_b0 = 16'(a0);
    v.e_sr1_b1 = 16'(a1);
    v.e_sr2_b0 = 16'(b0);
    v.e_sr2_b1 = 16'(b1);
    v.e_nzp    = 3'(nzp);
    v.e_ben    = 1'(ben);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    cur    = s;
    rst_n  = s.rst;
    bus    = s.bus;
    ir     = s.ir;
    drmux  = s.drmux;
    sr1mux = s.sr1mux;
    ldr    = s.ldr;
    ldc    = s.ldc;
    ldb    = s.ldb;
    #1;
  endtask

  // Architectural effect of one clock edge, ordered so BEN sees the old NZP.
  task automatic model_edge();
    logic [2:0] dr;
    if (!cur.rst) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0000;
      m_nzp = 3'b000;
      m_ben = 1'b0;
    end else begin
      dr = cur.drmux ? 3'd7 : cur.ir[11:9];
      if (cur.ldb) m_ben = ((cur.ir[11:9] & m_nzp) != 3'b000);
      if (cur.ldr) m_regs[dr] = cur.bus;
      if (cur.ldc) begin
        if ($signed(cur.bus) < 0)     m_nzp = 3'b100;
        else if (cur.bus == 16'h0000) m_nzp = 3'b010;
        else                          m_nzp = 3'b001;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [15:0] m_rd(input logic [2:0] a, input bit byp);
    logic [2:0] dr;
    dr = cur.drmux ? 3'd7 : cur.ir[11:9];
    if (byp && cur.ldr && dr == a) return cur.bus;
    return m_regs[a];
  endfunction

  task automatic check_reads_model(input string tag);
    logic [2:0] a1, a2;
    a1 = cur.sr1mux ? cur.ir[8:6] : cur.ir[11:9];
    a2 = cur.ir[2:0];
    chk({tag, " sr1_b0"}, if0.SR1_OUT, m_rd(a1, 1'b0));
    chk({tag, " sr1_b1"}, if1.SR1_OUT, m_rd(a1, 1'b1));
    chk({tag, " sr2_b0"}, if0.SR2_OUT, m_rd(a2, 1'b0));
    chk({tag, " sr2_b1"}, if1.SR2_OUT, m_rd(a2, 1'b1));
  endtask

  task automatic check_cc_model(input string tag);
    chk({tag, " nzp_b0"}, 16'(if0.NZP), 16'(m_nzp));
    chk({tag, " nzp_b1"}, 16'(if1.NZP), 16'(m_nzp));
    chk({tag, " ben_b0"}, 16'(if0.BEN), 16'(m_ben));
    chk({tag, " ben_b1"}, 16'(if1.BEN), 16'(m_ben));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " nzp_b0"}, 16'(if0.NZP), 16'h0000);
    chk({tag, " nzp_b1"}, 16'(if1.NZP), 16'h0000);
    chk({tag, " ben_b0"}, 16'(if0.BEN), 16'h0000);
    chk({tag, " ben_b1"}, 16'(if1.BEN), 16'h0000);
    for (int i = 0; i < 8; i++) begin
      drive(mk_s(1, 0, 0, i, 7 - i, 0, 1, 0, 0, 0));
      chk($sformatf("%s r%0d sr1_b0", tag, i), if0.SR1_OUT, 16'h0000);
      chk($sformatf("%s r%0d sr1_b1", tag, i), if1.SR1_OUT, 16'h0000);
      chk($sformatf("%s r%0d sr2_b0", tag, 7 - i), if0.SR2_OUT, 16'h0000);
      chk($sformatf("%s r%0d sr2_b1", tag, 7 - i), if1.SR2_OUT, 16'h0000);
      step();
    end
  endtask

  function automatic logic [15:0] rand_bus();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; bus = '0; ir = '0; drmux = 1'b0; sr1mux = 1'b0;
    ldr = 1'b0; ldc = 1'b0; ldb = 1'b0;
    cur = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (m_regs[i]) m_regs[i] = 16'h0000;
    m_nzp = 3'b000;
    m_ben = 1'b0;

    //              rst bus      dr s1 s2 dm sm lr lc lb   sr1_b0  sr1_b1  sr2_b0  sr2_b1  nzp ben
    vecs[0]  = mk_v(mk_s(1, 'hBEEF, 3, 0, 3, 0, 0, 1, 0, 0), 'h0000, 'hBEEF, 'h0000, 'hBEEF, 0, 0);
    vecs[1]  = mk_v(mk_s(1, 'h0000, 3, 0, 3, 0, 0, 0, 0, 0), 'hBEEF, 'hBEEF, 'hBEEF, 'hBEEF, 0, 0);
    vecs[2]  = mk_v(mk_s(1, 'h0000, 3, 0, 1, 0, 1, 0, 0, 0), 'h0000, 'h0000, 'h0000, 'h0000, 0, 0);
    vecs[3]  = mk_v(mk_s(1, 'h3001, 2, 0, 7, 1, 0, 1, 0, 0), 'h0000, 'h0000, 'h0000, 'h3001, 0, 0);
    vecs[4]  = mk_v(mk_s(1, 'h0000, 2, 0, 7, 0, 0, 0, 0, 0), 'h0000, 'h0000, 'h3001, 'h3001, 0, 0);
    vecs[5]  = mk_v(mk_s(1, 'h8000, 3, 0, 7, 0, 0, 0, 1, 0), 'hBEEF, 'hBEEF, 'h3001, 'h3001, 4, 0);
    vecs[6]  = mk_v(mk_s(1, 'h0000, 3, 0, 7, 0, 0, 0, 1, 0), 'hBEEF, 'hBEEF, 'h3001, 'h3001, 2, 0);
    vecs[7]  = mk_v(mk_s(1, 'h7FFF, 3, 0, 7, 0, 0, 0, 1, 0), 'hBEEF, 'hBEEF, 'h3001, 'h3001, 1, 0);
    vecs[8]  = mk_v(mk_s(1, 'h0000, 3, 0, 7, 0, 0, 0, 1, 0), 'hBEEF, 'hBEEF, 'h3001, 'h3001, 2, 0);
    vecs[9]  = mk_v(mk_s(1, 'h0005, 1, 0, 0, 0, 0, 0, 1, 1), 'h0000, 'h0000, 'h0000, 'h0000, 1, 0);
    vecs[10] = mk_v(mk_s(1, 'h0000, 1, 0, 0, 0, 0, 0, 0, 1), 'h0000, 'h0000, 'h0000, 'h0000, 1, 1);
    vecs[11] = mk_v(mk_s(1, 'h0011, 4, 0, 4, 0, 0, 1, 0, 0), 'h0000, 'h0011, 'h0000, 'h0011, 1, 1);
    vecs[12] = mk_v(mk_s(1, 'h0022, 4, 0, 4, 0, 0, 1, 0, 0), 'h0011, 'h0022, 'h0011, 'h0022, 1, 1);
    vecs[13] = mk_v(mk_s(1, 'h0000, 4, 0, 4, 0, 0, 0, 0, 0), 'h0022, 'h0022, 'h0022, 'h0022, 1, 1);
    vecs[14] = mk_v(mk_s(1, 'h8001, 5, 5, 4, 0, 1, 1, 1, 0), 'h0000, 'h8001, 'h0022, 'h0022, 4, 1);
    vecs[15] = mk_v(mk_s(1, 'h0000, 3, 5, 3, 0, 1, 0, 0, 1), 'h8001, 'h8001, 'hBEEF, 'hBEEF, 4, 0);
    vecs[16] = mk_v(mk_s(1, 'h0000, 4, 0, 0, 0, 0, 0, 0, 1), 'h0022, 'h0022, 'h0000, 'h0000, 4, 1);

    // Power-on reset, then confirm every register and flag reads zero.
    repeat (2) begin
      drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
    end
    check_cleared("por");

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].s);
      chk($sformatf("vec%0d sr1_b0", i), if0.SR1_OUT, vecs[i].e_sr1_b0);
      chk($sformatf("vec%0d sr1_b1", i), if1.SR1_OUT, vecs[i].e_sr1_b1);
      chk($sformatf("vec%0d sr2_b0", i), if0.SR2_OUT, vecs[i].e_sr2_b0);
      chk($sformatf("vec%0d sr2_b1", i), if1.SR2_OUT, vecs[i].e_sr2_b1);
      step();
      chk($sformatf("vec%0d nzp_b0", i), 16'(if0.NZP), 16'(vecs[i].e_nzp));
      chk($sformatf("vec%0d nzp_b1", i), 16'(if1.NZP), 16'(vecs[i].e_nzp));
      chk($sformatf("vec%0d ben_b0", i), 16'(if0.BEN), 16'(vecs[i].e_ben));
      chk($sformatf("vec%0d ben_b1", i), 16'(if1.BEN), 16'(vecs[i].e_ben));
    end

    // Scatter random writes, then reset during a cycle that also loads R4, CC and BEN.
    for (int i = 0; i < 8; i++) begin
      drive(mk_s(1, int'(rand_bus()), i, $urandom_range(0, 7), $urandom_range(0, 7), 0, 1, 1, 1, 0));
      check_reads_model($sformatf("pre_rst%0d", i));
      step();
      check_cc_model($sformatf("pre_rst%0d", i));
    end
    drive(mk_s(0, 'h0033, 4, 4, 4, 0, 0, 1, 1, 1));
    step();
    check_cleared("rst_mid");

    // Randomized traffic, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      s.rst    = ($urandom_range(0, 24) != 0);
      s.bus    = rand_bus();
      s.ir     = 16'($urandom);
      s.drmux  = 1'($urandom_range(0, 3) == 0);
      s.sr1mux = 1'($urandom_range(0, 1));
      s.ldr    = 1'($urandom_range(0, 1));
      s.ldc    = 1'($urandom_range(0, 1));
      s.ldb    = 1'($urandom_range(0, 2) == 0);
      drive(s);
      check_reads_model($sformatf("rnd%0d", n));
      step();
      check_cc_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
